// File: rtl/ex_mult_div_unit_if.sv
// Operand, control and HI/LO result bundle between the EX-stage datapath and the
// multiply/divide unit.
interface ex_mult_div_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  mthi;
  logic                  mtlo;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  busy;
  logic                  done;

  modport master (
    output start, op, operand_a, operand_b, mthi, mtlo, write_data,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, operand_a, operand_b, mthi, mtlo, write_data,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/ex_mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Signed ops run on magnitudes; signs are reapplied in a single fixup cycle.
module ex_mult_div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  ex_mult_div_unit_if.slave bus
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFixup} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Multiply: {upper product, multiplier}. Divide: {remainder, quotient}.
  logic [2*W-1:0]  acc_q, acc_d;
  // Multiplicand for multiply, divisor for divide.
  logic [W-1:0]    opnd_q, opnd_d;
  logic            is_div_q, is_div_d;
  logic            neg_lo_q, neg_lo_d;
  logic            neg_hi_q, neg_hi_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;

  logic           signed_op, sign_a, sign_b;
  logic [W-1:0]   abs_a, abs_b;
  logic [W:0]     add_sum, rem_shift, trial;
  logic [2*W-1:0] mul_next, div_next, prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  always_comb begin
    signed_op = ~bus.op[0];
    sign_a    = signed_op & bus.operand_a[W-1];
    sign_b    = signed_op & bus.operand_b[W-1];
    abs_a     = sign_a ? -bus.operand_a : bus.operand_a;
    abs_b     = sign_b ? -bus.operand_b : bus.operand_b;

    add_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {add_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

    // Restoring step; the extra bit keeps the shifted-out remainder MSB.
    rem_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    trial     = rem_shift - {1'b0, opnd_q};
    div_next  = trial[W] ? {acc_q[2*W-2:0], 1'b0} : {trial[W-1:0], acc_q[W-2:0], 1'b1};

    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quot_fix = neg_lo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix  = neg_hi_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          // Divide by zero keeps an all-ones quotient regardless of dividend sign.
          neg_lo_d = (sign_a ^ sign_b) & ~(bus.op[1] & (bus.operand_b == '0));
          neg_hi_d = sign_a;
          acc_d    = {{W{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
          opnd_d   = bus.op[1] ? abs_b : abs_a;
          cnt_d    = '0;
          state_d  = StRun;
        end else begin
          if (bus.mthi) hi_d = bus.write_data;
          if (bus.mtlo) lo_d = bus.write_data;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CntW'(W - 1)) state_d = StFixup;
      end
      StFixup: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;

endmodule
